// File: rtl/fmcw_usb_pkg.sv
// Shared constants, FSM encoding and checksum helper for the FT2232H packetizer.
// USB_TX_CHECKSUM_EN appends an XOR checksum byte to every packet.
package fmcw_usb_pkg;

  localparam logic [3:0] HDR_NIBBLE = 4'hF;
  localparam int         WORD_BITS  = 64;

`ifdef USB_TX_CHECKSUM_EN
  localparam int PKT_BYTES = 9;
`else
  localparam int PKT_BYTES = 8;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_FLUSH = 2'd2
  } tx_state_e;

  function automatic logic [7:0] xor_bytes(input logic [WORD_BITS-1:0] word);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < WORD_BITS / 8; i++) begin
      acc = acc ^ word[i*8 +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/usb_tx_fifo.sv
// Show-ahead synchronous FIFO with registered occupancy and registered full/empty flags.
module usb_tx_fifo #(
  parameter int WIDTH = 60,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("usb_tx_fifo: DEPTH must be a power of two");
  end

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [AW:0]      count_s;
  logic             full_r;
  logic             empty_r;

  // Next occupancy from this cycle's push/pop pair.
  always_comb begin
    count_s = count_r;
    case ({push_i, pop_i})
      2'b10:   count_s = count_r + CNT_ONE;
      2'b01:   count_s = count_r - CNT_ONE;
      default: count_s = count_r;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_i) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_i)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r <= count_s;
      full_r  <= (count_s == CNT_FULL);
      empty_r <= (count_s == CNT_ZERO);
    end
  end

  // Storage array, contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_r[wr_ptr_r] <= wdata_i;
  end

  assign rdata_o = mem_r[rd_ptr_r];
  assign full_o  = full_r;
  assign empty_o = empty_r;

endmodule

// File: rtl/fft_usb_packetizer.sv
// Packs FFT bins into {F,ctr,re,im} byte packets for the FT2232H sync FIFO with TXE# flow control.
// Define USB_TX_CHECKSUM_EN to append an XOR checksum as a ninth byte.
module fft_usb_packetizer
  import fmcw_usb_pkg::*;
#(
  parameter int N_WIDTH        = 10,
  parameter int DATA_WIDTH     = 25,
  parameter int USB_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      s_valid_i,
  output logic                      s_ready_o,
  input  logic [N_WIDTH-1:0]        s_ctr_i,
  input  logic [DATA_WIDTH-1:0]     s_re_i,
  input  logic [DATA_WIDTH-1:0]     s_im_i,
  input  logic                      ft_txe_n_i,
  input  logic                      ft_suspend_n_i,
  output logic                      ft_wr_n_o,
  output logic [USB_DATA_WIDTH-1:0] ft_data_o,
  output logic                      ft_siwua_n_o
);

  localparam int ENTRY_W  = WORD_BITS - 4;
  localparam int PKT_BITS = PKT_BYTES * 8;
  localparam logic [3:0] IDX_ZERO = 4'd0;
  localparam logic [3:0] IDX_ONE  = 4'd1;
  localparam logic [3:0] LAST_IDX = 4'(PKT_BYTES - 1);

  if (4 + N_WIDTH + 2 * DATA_WIDTH != WORD_BITS || USB_DATA_WIDTH != 8) begin : g_width_check
    $error("fft_usb_packetizer: bin fields must pack into exactly 64 bits on an 8-bit bus");
  end

  logic [ENTRY_W-1:0]   fifo_rdata_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 advance_s;
  logic                 start_ok_s;
  logic                 byte_acc_s;
  logic                 last_byte_s;
  logic [WORD_BITS-1:0] word_s;
  logic [PKT_BITS-1:0]  pkt_s;
  tx_state_e            state_r;
  tx_state_e            state_s;
  logic [PKT_BITS-1:0]  shift_r;
  logic [3:0]           byte_idx_r;
  logic                 last_ctr_r;
  logic                 wr_n_r;
  logic                 wr_n_s;
  logic                 siwua_n_r;
  logic                 siwua_n_s;

  assign push_s = s_valid_i && !fifo_full_s;

  usb_tx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_s),
    .wdata_i ({s_ctr_i, s_re_i, s_im_i}),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign word_s = {HDR_NIBBLE, fifo_rdata_s};
`ifdef USB_TX_CHECKSUM_EN
  assign pkt_s = {word_s, xor_bytes(word_s)};
`else
  assign pkt_s = word_s;
`endif

  assign start_ok_s  = !fifo_empty_s && ft_suspend_n_i;
  assign byte_acc_s  = !wr_n_r && !ft_txe_n_i;
  assign last_byte_s = (byte_idx_r == LAST_IDX);

  // Next state and next registered strobes; TXE# only ever reaches flop inputs.
  always_comb begin
    state_s   = state_r;
    pop_s     = 1'b0;
    advance_s = 1'b0;
    wr_n_s    = wr_n_r;
    siwua_n_s = 1'b1;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          pop_s   = 1'b1;
          wr_n_s  = 1'b0;
          state_s = ST_SEND;
        end else begin
          wr_n_s  = 1'b1;
        end
      end
      ST_SEND: begin
        wr_n_s = 1'b0;
        if (!byte_acc_s) begin
          advance_s = 1'b0;
        end else if (!last_byte_s) begin
          advance_s = 1'b1;
        end else if (last_ctr_r) begin
          wr_n_s    = 1'b1;
          siwua_n_s = 1'b0;
          state_s   = ST_FLUSH;
        end else if (start_ok_s) begin
          pop_s     = 1'b1;
        end else begin
          wr_n_s    = 1'b1;
          state_s   = ST_IDLE;
        end
      end
      // The flush cycle also makes the idle decision so a frame costs only one extra cycle.
      ST_FLUSH: begin
        if (start_ok_s) begin
          pop_s   = 1'b1;
          wr_n_s  = 1'b0;
          state_s = ST_SEND;
        end else begin
          wr_n_s  = 1'b1;
          state_s = ST_IDLE;
        end
      end
      default: begin
        wr_n_s  = 1'b1;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, packet shift register and output strobes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      shift_r    <= '0;
      byte_idx_r <= IDX_ZERO;
      last_ctr_r <= 1'b0;
      wr_n_r     <= 1'b1;
      siwua_n_r  <= 1'b1;
    end else begin
      state_r   <= state_s;
      wr_n_r    <= wr_n_s;
      siwua_n_r <= siwua_n_s;
      if (pop_s) begin
        shift_r    <= pkt_s;
        byte_idx_r <= IDX_ZERO;
        last_ctr_r <= (fifo_rdata_s[ENTRY_W-1 -: N_WIDTH] == {N_WIDTH{1'b1}});
      end else if (advance_s) begin
        shift_r    <= {shift_r[PKT_BITS-9:0], 8'h00};
        byte_idx_r <= byte_idx_r + IDX_ONE;
      end else begin
        shift_r    <= shift_r;
        byte_idx_r <= byte_idx_r;
      end
    end
  end

  assign s_ready_o    = !fifo_full_s;
  assign ft_wr_n_o    = wr_n_r;
  assign ft_siwua_n_o = siwua_n_r;
  assign ft_data_o    = shift_r[PKT_BITS-1 -: USB_DATA_WIDTH];

endmodule

// File: tb/tb_fft_usb_packetizer.sv
// Randomized bench for fft_usb_packetizer against a byte-queue reference model.
module tb_fft_usb_packetizer;

  localparam int NW = 10;
  localparam int DW = 25;
  localparam int FD = 16;
`ifdef USB_TX_CHECKSUM_EN
  localparam int PB = 9;
`else
  localparam int PB = 8;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [NW-1:0] s_ctr;
  logic [DW-1:0] s_re;
  logic [DW-1:0] s_im;
  logic          txe_n;
  logic          suspend_n;
  logic          wr_n;
  logic [7:0]    data;
  logic          siwua_n;

  fft_usb_packetizer #(
    .N_WIDTH(NW), .DATA_WIDTH(DW), .USB_DATA_WIDTH(8), .FIFO_DEPTH(FD)
  ) dut (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .s_ctr_i(s_ctr), .s_re_i(s_re), .s_im_i(s_im),
    .ft_txe_n_i(txe_n), .ft_suspend_n_i(suspend_n),
    .ft_wr_n_o(wr_n), .ft_data_o(data), .ft_siwua_n_o(siwua_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: expected byte stream, bit 8 marks the byte that must be followed by SIWUA#.
  logic [8:0] exp_q[$];

  task automatic model_push(input logic [NW-1:0] c, input logic [DW-1:0] re, input logic [DW-1:0] im);
    logic [63:0] w;
    logic [7:0]  b;
    logic [7:0]  cs;
    logic        frame_end;
    w = {4'hF, c, re, im};
    cs = 8'h00;
    frame_end = (c == {NW{1'b1}});
    for (int i = 0; i < 8; i++) begin
      b = w[63 - 8*i -: 8];
      cs = cs ^ b;
      exp_q.push_back({frame_end && (i == PB - 1), b});
    end
    if (PB == 9) exp_q.push_back({frame_end, cs});
  endtask

  // Bus monitor, sampled on the falling edge.
  int   acc_cnt = 0;
  int   wr_low_cnt = 0;
  int   siwua_low_cnt = 0;
  int   last_acc_cyc = 0;
  int   first_wr_cyc = -1;
  bit   exp_flush = 1'b0;
  bit   ready_low_seen = 1'b0;
  logic [8:0] mon_e;

  always @(negedge clk) begin
    if (rst) begin
      exp_flush = 1'b0;
    end else begin
      if (exp_flush || !siwua_n) check_eq("siwua", siwua_n, !exp_flush);
      if (!siwua_n) siwua_low_cnt++;
      exp_flush = 1'b0;
      if (!s_ready) ready_low_seen = 1'b1;
      if (!wr_n) begin
        wr_low_cnt++;
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
      end
      if (!wr_n && !txe_n) begin
        acc_cnt++;
        last_acc_cyc = cyc;
        check_eq("byte_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check_eq("byte", data, mon_e[7:0]);
          exp_flush = mon_e[8];
        end
      end
    end
  end

  int acc_push_cyc;

  task automatic push_bin(input logic [NW-1:0] c, input logic [DW-1:0] re, input logic [DW-1:0] im);
    int waitc;
    s_valid = 1'b1; s_ctr = c; s_re = re; s_im = im;
    waitc = 0;
    @(negedge clk);
    while (!s_ready && waitc < 2000) begin
      @(negedge clk);
      waitc++;
    end
    check_eq("push_ready", s_ready, 1);
    @(posedge clk);
    if (s_ready) model_push(c, re, im);
    #1;
    acc_push_cyc = cyc;
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !wr_n) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain_done", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_bytes(input int base, input int n);
    int t;
    t = 0;
    while (acc_cnt - base < n && t < 500) begin
      @(posedge clk);
      t++;
    end
    check_eq("byte_progress", acc_cnt - base, n);
  endtask

  int k0, a0, w0, f0, accepted;
  bit r, done;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_ctr = '0; s_re = '0; s_im = '0;
    txe_n = 1'b0; suspend_n = 1'b1;
    #12;
    check_eq("rst_wr_n", wr_n, 1);
    check_eq("rst_siwua_n", siwua_n, 1);
    check_eq("rst_data", data, 0);
    check_eq("rst_ready", s_ready, 1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Known bin, TXE# held low: exact bytes, burst length and latency.
    first_wr_cyc = -1; w0 = wr_low_cnt;
    push_bin(10'h155, 25'h0ABCDEF, 25'h1234567);
    k0 = acc_push_cyc;
    wait_drain();
    check_eq("t1_wr_cycles", wr_low_cnt - w0, PB);
    check_eq("t1_latency", first_wr_cyc - k0, 1);

    // TXE# high for 3 cycles while byte 3 is on the bus.
    a0 = acc_cnt;
    push_bin(NW'($urandom_range(0, 1022)), DW'($urandom), DW'($urandom));
    wait_bytes(a0, 3);
    #1 txe_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("t2_hold_data", data, exp_q[0][7:0]);
      check_eq("t2_hold_wr", wr_n, 0);
      @(posedge clk);
    end
    #1 txe_n = 1'b0;
    wait_drain();
    check_eq("t2_total", acc_cnt - a0, PB);

    // Full frame at line rate: continuous WR#, one SIWUA# pulse, FIFO never full.
    ready_low_seen = 1'b0; first_wr_cyc = -1; f0 = siwua_low_cnt; a0 = acc_cnt;
    for (int c = 0; c < 1024; c++) begin
      push_bin(NW'(c), DW'($urandom), DW'($urandom));
      repeat (PB - 1) @(posedge clk);
      #1;
    end
    wait_drain();
    check_eq("t3_no_gap", last_acc_cyc - first_wr_cyc + 1, 1024 * PB);
    check_eq("t3_bytes", acc_cnt - a0, 1024 * PB);
    check_eq("t3_siwua_pulses", siwua_low_cnt - f0, 1);
    check_eq("t3_never_full", ready_low_seen, 0);

    // Host stalled: one packet in the shift register plus FD queued before ready drops.
    txe_n = 1'b1; accepted = 0; a0 = acc_cnt;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1; s_ctr = NW'($urandom_range(0, 1022)); s_re = DW'($urandom); s_im = DW'($urandom);
      @(negedge clk); r = s_ready;
      @(posedge clk);
      if (r) begin
        model_push(s_ctr, s_re, s_im);
        accepted++;
      end
      #1;
    end
    s_valid = 1'b0;
    check_eq("t4_accepted", accepted, FD + 1);
    check_eq("t4_ready_low", s_ready, 0);
    repeat (180) @(posedge clk);
    #1;
    check_eq("t4_no_bytes_stalled", acc_cnt - a0, 0);
    txe_n = 1'b0;
    wait_drain();
    check_eq("t4_total", acc_cnt - a0, (FD + 1) * PB);

    // Suspended: queued bins must not start until resume.
    suspend_n = 1'b0; w0 = wr_low_cnt; a0 = acc_cnt;
    push_bin(NW'($urandom_range(0, 1022)), DW'($urandom), DW'($urandom));
    push_bin(NW'($urandom_range(0, 1022)), DW'($urandom), DW'($urandom));
    repeat (30) @(posedge clk);
    #1;
    check_eq("t5_no_wr_suspended", wr_low_cnt - w0, 0);
    suspend_n = 1'b1;
    wait_drain();
    check_eq("t5_total", acc_cnt - a0, 2 * PB);

    // Reset during byte 5 with a second bin queued.
    a0 = acc_cnt;
    push_bin(NW'($urandom_range(0, 1022)), DW'($urandom), DW'($urandom));
    push_bin(NW'($urandom_range(0, 1022)), DW'($urandom), DW'($urandom));
    wait_bytes(a0, 5);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_wr_n", wr_n, 1);
    check_eq("t6_siwua_n", siwua_n, 1);
    check_eq("t6_ready", s_ready, 1);
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    w0 = wr_low_cnt;
    repeat (6) @(posedge clk);
    #1;
    check_eq("t6_fifo_empty", wr_low_cnt - w0, 0);
    first_wr_cyc = -1; a0 = acc_cnt;
    push_bin(NW'($urandom_range(0, 1022)), DW'($urandom), DW'($urandom));
    k0 = acc_push_cyc;
    wait_drain();
    check_eq("t6_latency", first_wr_cyc - k0, 1);
    check_eq("t6_total", acc_cnt - a0, PB);

    // Random bins, random gaps and random TXE# throttling.
    a0 = acc_cnt; done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          push_bin(NW'($urandom), DW'($urandom), DW'($urandom));
          repeat ($urandom_range(0, 12)) @(posedge clk);
          #1;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 txe_n = ($urandom_range(0, 3) == 0);
        end
        txe_n = 1'b0;
      end
    join
    wait_drain();
    check_eq("t7_total", acc_cnt - a0, 40 * PB);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
